// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants, record layout, FSM states and helpers for the NN sample sequencer
package nn_pkg;

    // Default width of one signed sample field (x*, desired_y*).
    localparam int XW     = 9;
    // Fields per sample record, stored as {x0,x1,x2,x3,desired_y0,desired_y1} with x0 in the MSBs.
    localparam int NFIELD = 6;

    localparam int F_X0  = 0;
    localparam int F_X1  = 1;
    localparam int F_X2  = 2;
    localparam int F_X3  = 3;
    localparam int F_DY0 = 4;
    localparam int F_DY1 = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nn_state_e;

    // LSB position of field f inside a record built from xw-bit fields.
    function automatic int field_lsb(input int f, input int xw);
        return (NFIELD - 1 - f) * xw;
    endfunction

    // Increment that sticks at vmax instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
        return (v >= vmax) ? vmax : v + 32'd1;
    endfunction

endpackage

// File: rtl/nn_sample_table.sv
// rtl/nn_sample_table.sv - DEPTH x DW sample register file, one write port, one combinational read
//
// Ports:
//   CLK      in   clock, rising edge
//   wr_en    in   write strobe (already qualified by the caller)
//   wr_addr  in   write address
//   wr_data  in   record to store
//   rd_addr  in   read address
//   rd_data  out  record at rd_addr (combinational)
// Contents have no reset so a loaded table survives a reset of the sequencer.
module nn_sample_table #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = nn_pkg::NFIELD * nn_pkg::XW
) (
    input  logic          CLK,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/nn_sample_sequencer.sv
// rtl/nn_sample_sequencer.sv - drives stored training samples into the network and counts output mismatches
//
// Ports:
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   wr_en/wr_addr/wr_data table write port, ignored while busy
//   num_samples          active table entries (1..DEPTH), captured on start
//   start                run request pulse
//   y0, y1               network outputs
//   x0..x3, desired_y0/1 registered signed sample fields presented to the network
//   sample_valid         outputs carry a live sample
//   busy, done           run in progress / run finished (level until next start)
//   err_count            saturating count of mismatching samples this run
//   epoch_cnt            completed passes over the table this run
// Build option: NN_SEQ_STOP_ON_CONVERGE_EN ends the run after the first epoch with no mismatches.
module nn_sample_sequencer #(
    parameter int XW          = nn_pkg::XW,
    parameter int DEPTH       = 8,
    parameter int AW          = $clog2(DEPTH),
    parameter int HOLD_CYCLES = 24,
    parameter int EPOCHS      = 16,
    parameter int CW          = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [6*XW-1:0]      wr_data,
    input  logic [AW:0]          num_samples,
    input  logic                 start,
    input  logic                 y0,
    input  logic                 y1,
    output logic signed [XW-1:0] x0,
    output logic signed [XW-1:0] x1,
    output logic signed [XW-1:0] x2,
    output logic signed [XW-1:0] x3,
    output logic signed [XW-1:0] desired_y0,
    output logic signed [XW-1:0] desired_y1,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        err_count,
    output logic [CW-1:0]        epoch_cnt
);
    import nn_pkg::*;

    localparam int DW      = NFIELD * XW;
    localparam int X0_LSB  = field_lsb(F_X0, XW);
    localparam int X1_LSB  = field_lsb(F_X1, XW);
    localparam int X2_LSB  = field_lsb(F_X2, XW);
    localparam int X3_LSB  = field_lsb(F_X3, XW);
    localparam int DY0_LSB = field_lsb(F_DY0, XW);
    localparam int DY1_LSB = field_lsb(F_DY1, XW);
    localparam int HW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [31:0]   CNT_MAX   = (CW >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << CW) - 64'd1);

    nn_state_e     state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW:0]   nsamp_q, nsamp_d;
    logic [DW-1:0] rec_q, rec_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] err_q, err_d;
    logic [CW-1:0] epoch_q, epoch_d;
`ifdef NN_SEQ_STOP_ON_CONVERGE_EN
    logic [CW-1:0] ep_err_q, ep_err_d;
`endif

    logic [DW-1:0] rd_data;
    logic          start_ok;
    logic          mism;
    logic          last_idx;
    logic          finish;

    nn_sample_table #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_table (
        .CLK     (CLK),
        .wr_en   (wr_en && !busy_q),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    assign start_ok = start && (num_samples != '0) && (32'(num_samples) <= 32'(DEPTH));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        nsamp_d  = nsamp_q;
        rec_d    = rec_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        epoch_d  = epoch_q;
`ifdef NN_SEQ_STOP_ON_CONVERGE_EN
        ep_err_d = ep_err_q;
`endif
        mism     = 1'b0;
        last_idx = 1'b0;
        finish   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d  = RUN;
                    idx_d    = '0;
                    hold_d   = '0;
                    nsamp_d  = num_samples;
                    valid_d  = 1'b0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = '0;
                    epoch_d  = '0;
`ifdef NN_SEQ_STOP_ON_CONVERGE_EN
                    ep_err_d = '0;
`endif
                end
            end
            RUN: begin
                // Output record lags idx by one clock; the window is still HOLD_CYCLES long
                // because idx and the record both advance once per window.
                rec_d   = rd_data;
                valid_d = 1'b1;
                if (hold_q == HOLD_LAST) begin
                    // rec_q already shows table[idx] here since HOLD_CYCLES >= 2.
                    mism     = (y0 != rec_q[DY0_LSB]) || (y1 != rec_q[DY1_LSB]);
                    last_idx = ({1'b0, idx_q} == (nsamp_q - (AW+1)'(1)));
                    hold_d   = '0;
                    if (mism) begin
                        err_d = CW'(sat_inc(32'(err_q), CNT_MAX));
                    end
                    if (last_idx) begin
                        idx_d   = '0;
                        epoch_d = epoch_q + CW'(1);
                        if (32'(epoch_q) + 32'd1 == 32'(EPOCHS)) begin
                            finish = 1'b1;
                        end
`ifdef NN_SEQ_STOP_ON_CONVERGE_EN
                        if ((ep_err_q == '0) && !mism) begin
                            finish = 1'b1;
                        end
                        ep_err_d = '0;
`endif
                    end else begin
                        idx_d = idx_q + AW'(1);
`ifdef NN_SEQ_STOP_ON_CONVERGE_EN
                        if (mism) begin
                            ep_err_d = CW'(sat_inc(32'(ep_err_q), CNT_MAX));
                        end
`endif
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
                if (finish) begin
                    state_d = DONE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            hold_q   <= '0;
            nsamp_q  <= '0;
            rec_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= '0;
            epoch_q  <= '0;
`ifdef NN_SEQ_STOP_ON_CONVERGE_EN
            ep_err_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            nsamp_q  <= nsamp_d;
            rec_q    <= rec_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            epoch_q  <= epoch_d;
`ifdef NN_SEQ_STOP_ON_CONVERGE_EN
            ep_err_q <= ep_err_d;
`endif
        end
    end

    assign x0           = rec_q[X0_LSB  +: XW];
    assign x1           = rec_q[X1_LSB  +: XW];
    assign x2           = rec_q[X2_LSB  +: XW];
    assign x3           = rec_q[X3_LSB  +: XW];
    assign desired_y0   = rec_q[DY0_LSB +: XW];
    assign desired_y1   = rec_q[DY1_LSB +: XW];
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_count    = err_q;
    assign epoch_cnt    = epoch_q;

endmodule

// File: tb/tb_nn_sample_sequencer.sv
// tb/tb_nn_sample_sequencer.sv - scoreboard bench for nn_sample_sequencer
module tb_nn_sample_sequencer;

    localparam int XW = 9;
    localparam int AW = 3;
    localparam int DW = 6 * XW;
    localparam int HM = 24;
    localparam int EM = 2;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW:0]   num_samples = '0;
    logic          start_m = 1'b0, start_s = 1'b0, start_l = 1'b0;
    logic          m_mode = 1'b0, l_match = 1'b0;

    logic signed [XW-1:0] m_x0, m_x1, m_x2, m_x3, m_dy0, m_dy1;
    logic signed [XW-1:0] s_x0, s_x1, s_x2, s_x3, s_dy0, s_dy1;
    logic signed [XW-1:0] l_x0, l_x1, l_x2, l_x3, l_dy0, l_dy1;
    logic        m_sv, m_busy, m_done, s_sv, s_busy, s_done, l_sv, l_busy, l_done;
    logic [15:0] m_err, m_ep, l_err, l_ep;
    logic [3:0]  s_err, s_ep;
    logic        y0_m, y1_m, y0_l, y1_l;

    // y follows the presented target (match) or is held at 1/0 (mismatch for every table entry here)
    assign y0_m = m_mode ? 1'b1 : m_dy0[0];
    assign y1_m = m_mode ? 1'b0 : m_dy1[0];
    assign y0_l = l_match ? l_dy0[0] : 1'b1;
    assign y1_l = l_match ? l_dy1[0] : 1'b0;

    nn_sample_sequencer #(.EPOCHS(EM)) u_main (
        .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_samples(num_samples), .start(start_m), .y0(y0_m), .y1(y1_m),
        .x0(m_x0), .x1(m_x1), .x2(m_x2), .x3(m_x3), .desired_y0(m_dy0), .desired_y1(m_dy1),
        .sample_valid(m_sv), .busy(m_busy), .done(m_done), .err_count(m_err), .epoch_cnt(m_ep));

    nn_sample_sequencer #(.HOLD_CYCLES(4), .EPOCHS(4), .CW(4)) u_sat (
        .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_samples(num_samples), .start(start_s), .y0(1'b1), .y1(1'b0),
        .x0(s_x0), .x1(s_x1), .x2(s_x2), .x3(s_x3), .desired_y0(s_dy0), .desired_y1(s_dy1),
        .sample_valid(s_sv), .busy(s_busy), .done(s_done), .err_count(s_err), .epoch_cnt(s_ep));

    nn_sample_sequencer #(.HOLD_CYCLES(4), .EPOCHS(16), .CW(16)) u_long (
        .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_samples(num_samples), .start(start_l), .y0(y0_l), .y1(y1_l),
        .x0(l_x0), .x1(l_x1), .x2(l_x2), .x3(l_x3), .desired_y0(l_dy0), .desired_y1(l_dy1),
        .sample_valid(l_sv), .busy(l_busy), .done(l_done), .err_count(l_err), .epoch_cnt(l_ep));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rec(input int a, input int b, input int c,
                                          input int d, input int e, input int f);
        return {XW'(a), XW'(b), XW'(c), XW'(d), XW'(e), XW'(f)};
    endfunction

    function automatic logic mism(input logic [DW-1:0] r, input logic ya, input logic yb);
        return (ya != r[XW]) || (yb != r[0]);
    endfunction

    logic [DW-1:0] tbl [5];
    logic [DW-1:0] exp_q[$];
    logic [31:0]   fin_q[$];
    logic          mon_en = 1'b0;
    logic          sv_prev = 1'b0;
    int            win = 0;

    // Scoreboard monitor: a new sample window starts when valid rises or after HM valid cycles.
    always @(negedge CLK) begin
        if (!mon_en) begin
            sv_prev = 1'b0;
            win = 0;
        end else begin
            if (m_sv && (!sv_prev || win == HM)) begin
                chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("sample", 64'({m_x0, m_x1, m_x2, m_x3, m_dy0, m_dy1}), 64'(exp_q.pop_front()));
                end
                win = 1;
            end else if (m_sv) begin
                win++;
            end
            sv_prev = m_sv;
        end
    end

    task automatic start_main(input int n, input bit do_wr, input logic [DW-1:0] wdata);
        int errs;
        if (do_wr) tbl[0] = wdata;
        errs = 0;
        for (int e = 0; e < EM; e++) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(tbl[i]);
                if (m_mode && mism(tbl[i], 1'b1, 1'b0)) errs++;
            end
        end
        fin_q.push_back({16'(errs), 16'(EM)});
        mon_en = 1'b1;
        num_samples = (AW+1)'(n);
        @(posedge CLK); #1;
        start_m = 1'b1;
        if (do_wr) begin
            wr_en = 1'b1; wr_addr = '0; wr_data = wdata;
        end
        @(posedge CLK); #1;
        start_m = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic finish_main(input bit wr_mid, input int exp_cyc);
        int cnt;
        cnt = 0;
        while (!m_done && cnt < 2000) begin
            @(posedge CLK); #1;
            cnt++;
            if (wr_mid && cnt == 30) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = rec(1, 2, 3, 4, 1, 0);
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        chk("done_latency", 64'(cnt), 64'(exp_cyc));
        chk("fin_pending", 64'(fin_q.size() != 0), 64'd1);
        if (fin_q.size() != 0) chk("err_epoch", 64'({m_err, m_ep}), 64'(fin_q.pop_front()));
        chk("busy_after_done", 64'(m_busy), 64'd0);
        chk("samples_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int cnt;
        int exp_s;
        int exp_l_err;
        int exp_l_ep;

        #2 RST_N = 1'b0;
        #1;
        chk("rst_ctl", 64'({m_sv, m_busy, m_done, m_err, m_ep}), 64'd0);
        chk("rst_data", 64'({m_x0, m_x1, m_x2, m_x3, m_dy0, m_dy1}), 64'd0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;

        tbl[0] = rec(159, 205, 81, 76, 0, 1);
        tbl[1] = rec(12, -40, 100, -7, 1, 1);
        tbl[2] = rec(-128, 255, -256, 3, 1, 1);
        tbl[3] = rec(33, 44, 55, 66, 0, 1);
        tbl[4] = rec(78, 101, 214, 226, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = tbl[i];
        end
        @(posedge CLK); #1 wr_en = 1'b0;

        // Out-of-range num_samples leaves the sequencer idle.
        foreach (tbl[k]) begin end
        for (int ns = 0; ns <= 9; ns += 9) begin
            num_samples = (AW+1)'(ns);
            start_m = 1'b1;
            @(posedge CLK); #1 start_m = 1'b0;
            repeat (3) @(posedge CLK);
            #1 chk($sformatf("bad_start_%0d", ns), 64'({m_busy, m_sv, m_done}), 64'd0);
        end

        m_mode = 1'b0;
        start_main(5, 1'b0, '0);
        finish_main(1'b0, 240);

        m_mode = 1'b1;
        start_main(5, 1'b0, '0);
        finish_main(1'b1, 240);

        // Reset in the middle of a run, then restart with a same-cycle write to entry 0.
        m_mode = 1'b0;
        start_main(5, 1'b0, '0);
        repeat (50) @(posedge CLK);
        #3;
        mon_en = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("midrst_ctl", 64'({m_sv, m_busy, m_done, m_err, m_ep}), 64'd0);
        chk("midrst_data", 64'({m_x0, m_x1, m_x2, m_x3, m_dy0, m_dy1}), 64'd0);
        exp_q.delete();
        fin_q.delete();
        @(negedge CLK) RST_N = 1'b1;
        start_main(5, 1'b1, rec(-1, 2, -3, 4, 0, 0));
        finish_main(1'b0, 240);
        mon_en = 1'b0;

        // Saturation with a 4-bit counter: 4 epochs x 5 mismatching samples.
        exp_s = 0;
        for (int e = 0; e < 4; e++)
            for (int i = 0; i < 5; i++)
                if (mism(tbl[i], 1'b1, 1'b0)) exp_s = (exp_s < 15) ? exp_s + 1 : 15;
        num_samples = 4'd5;
        @(posedge CLK); #1 start_s = 1'b1;
        @(posedge CLK); #1 start_s = 1'b0;
        cnt = 0;
        while (!s_done && cnt < 500) begin
            @(posedge CLK); #1 cnt++;
        end
        chk("sat_done", 64'(s_done), 64'd1);
        chk("sat_err", 64'(s_err), 64'(exp_s));
        chk("sat_epoch", 64'(s_ep), 64'd4);

        // First epoch mismatches, later epochs match.
        exp_l_err = 0;
        for (int i = 0; i < 5; i++) if (mism(tbl[i], 1'b1, 1'b0)) exp_l_err++;
`ifdef NN_SEQ_STOP_ON_CONVERGE_EN
        exp_l_ep = 2;
`else
        exp_l_ep = 16;
`endif
        l_match = 1'b0;
        @(posedge CLK); #1 start_l = 1'b1;
        @(posedge CLK); #1 start_l = 1'b0;
        cnt = 0;
        while (!l_done && cnt < 1000) begin
            @(posedge CLK); #1 cnt++;
            if (cnt == 21) l_match = 1'b1;
        end
        chk("long_done", 64'(l_done), 64'd1);
        chk("long_epoch", 64'(l_ep), 64'(exp_l_ep));
        chk("long_err", 64'(l_err), 64'(exp_l_err));
        chk("long_cycles", 64'(cnt), 64'(exp_l_ep * 20));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
